wb_stage_p: RTL and testbench
=============================

Name: wb_stage_p

Overview:
- Parametrised write-back stage. It sits between the MEM stage and the register file.
- Registers one instruction per cycle and selects among four result sources: ALU, memory, PC link, immediate.
- For loads it extracts and sign/zero-extends byte/half/word data, and waits on a late memory response with a valid/ready handshake.
- Drives the register-file write port and a forwarding copy of the value being written.

Parameters:
- DATA_W, 32, datapath width. Must be a multiple of 16, minimum 32.
- RADDR_W, 6, register address width (64 registers).
- ZERO_REG_EN, 1, when 1, writes to address 0 are suppressed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  MEM-stage instruction present
- in_ready  out  1  stage can accept an instruction this cycle
- wb_sel  in  2  0=ALU, 1=MEM, 2=PC link, 3=immediate
- reg_write  in  1  instruction writes the register file
- rd  in  RADDR_W  destination register
- alu_result  in  DATA_W  ALU output
- pc_link  in  DATA_W  return address
- imm  in  DATA_W  immediate value
- ld_size  in  2  0=byte, 1=half, 2=word (3 is treated as word)
- ld_signed  in  1  sign-extend a sub-word load
- ld_offset  in  2  byte offset within the word
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  DATA_W  memory read data
- rf_we  out  1  register-file write enable
- rf_waddr  out  RADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- fwd_valid  out  1  forwarding value valid (equals rf_we)
- fwd_rd  out  RADDR_W  forwarding destination
- fwd_data  out  DATA_W  forwarding data

Behaviour:
- Reset: state=IDLE, in_ready=1, rf_we=0, fwd_valid=0, rf_waddr=0, rf_wdata=0, fwd_rd=0, fwd_data=0. Any pending load is discarded.
- Accept rule: a transfer occurs when in_valid && in_ready.
- Non-load accept (wb_sel≠1): next cycle rf_we=reg_write, rf_waddr=rd, rf_wdata=selected source. Latency 1, and in_ready stays 1.
- Load accept with mem_rvalid=1 in the same cycle: extracted data is written next cycle. Latency 1.
- Load accept with mem_rvalid=0:
  - Latch rd, reg_write, ld_size, ld_signed and ld_offset; go to WAIT_MEM; in_ready=0.
  - In WAIT_MEM, rf_we=0 until mem_rvalid=1.
  - The cycle after mem_rvalid is seen, the write is issued and the state returns to IDLE, with in_ready=1 in that same cycle.
- mem_rvalid is ignored outside a pending load or a same-cycle load accept.
- rf_we is a single-cycle pulse per instruction. With no accept and no completing load, rf_we=0 and the data outputs hold their last values.
- Load extraction, with byte lane k = ld_offset:
  - Byte: lane k of mem_rdata[31:0].
  - Half: bits [16*ld_offset[1] +: 16]; ld_offset[0] is ignored (no misalignment trap).
  - Word: mem_rdata unchanged.
  - Extension: sign-extend when ld_signed=1, zero-extend otherwise, up to DATA_W.
- Zero register: with ZERO_REG_EN=1 and rd==0, rf_we and fwd_valid stay 0. The data still updates.
- Forwarding outputs mirror the registered rf_* outputs exactly, with no extra latency.
- Reset asserted in WAIT_MEM forces IDLE next cycle. A mem_rvalid arriving in that reset cycle is dropped.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt (32 bits), reset to 0.
  - Increments on every cycle in which an instruction completes write-back, including reg_write=0 and suppressed zero-register writes.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Package wb_pkg holds:
  - wb_sel encodings WB_ALU=0, WB_MEM=1, WB_PC=2, WB_IMM=3.
  - ld_size encodings LD_B=0, LD_H=1, LD_W=2.
  - FSM state typedef (IDLE, WAIT_MEM).
- One sub-module, wb_load_align: combinational extraction and extension of (mem_rdata, ld_size, ld_signed, ld_offset), parametrised by DATA_W.
- The source mux stays in the parent.

Test Plan:
- ALU path: in_valid=1, wb_sel=0, reg_write=1, rd=5, alu_result=0x0000_1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234, fwd_data equal; the cycle after, rf_we=0.
- Signed byte load: wb_sel=1, ld_size=0, ld_signed=1, ld_offset=2, mem_rvalid=1, mem_rdata=0x1180_2233 → rf_wdata=0xFFFF_FF80. Repeat with ld_signed=0 → 0x0000_0080.
- Late memory:
  - Load accepted with mem_rvalid=0; mem_rvalid=1 with mem_rdata=0xCAFE_BABE three cycles later (word, rd=9).
  - Required: in_ready=0 for 3 cycles plus the response cycle; rf_we=0 throughout; a single write of 0xCAFE_BABE to r9; in_ready=1 in the write cycle.
- Zero register: reg_write=1, rd=0, alu_result=0xFFFF_FFFF → rf_we=0, fwd_valid=0. With WB_RETIRE_CNT_EN defined, retire_cnt increments by 1.
- Reset mid-wait: enter WAIT_MEM, assert rst for one cycle concurrent with mem_rvalid=1 → no write occurs; the stage is in IDLE with in_ready=1 after reset.
- Back-to-back: four ALU/PC/imm instructions on consecutive cycles with rd=1..4 → four consecutive rf_we pulses with correct data. Halfword unsigned load at offset 2 of 0xABCD_0001 → 0x0000_ABCD.

Source files
------------

// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared encodings and FSM state type for the write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_load_align.sv
// ============================================================================
// Module      : wb_load_align
// Description : Extracts a byte/half/word from load data and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [1:0]        ld_size_i,
    input  logic              ld_signed_i,
    input  logic [1:0]        ld_offset_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    // Halfword lane uses only offset[1]; an odd offset is silently aligned down.
    always_comb begin
        byte_w = mem_rdata_i[{ld_offset_i, 3'b000} +: 8];
        half_w = mem_rdata_i[{ld_offset_i[1], 4'b0000} +: 16];
        case (ld_size_i)
            LD_B:    ld_data_o = {{(DATA_W-8){ld_signed_i & byte_w[7]}}, byte_w};
            LD_H:    ld_data_o = {{(DATA_W-16){ld_signed_i & half_w[15]}}, half_w};
            default: ld_data_o = mem_rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage_p.sv
// ============================================================================
// Module      : wb_stage_p
// Description : Write-back stage: source select, load alignment, late-memory
//               wait, register-file write and forwarding. Optional retire
//               counter enabled by defining WB_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_p
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 6,
    parameter int ZERO_REG_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         wb_sel,
    input  logic               reg_write,
    input  logic [RADDR_W-1:0] rd,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  pc_link,
    input  logic [DATA_W-1:0]  imm,
    input  logic [1:0]         ld_size,
    input  logic               ld_signed,
    input  logic [1:0]         ld_offset,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]        retire_cnt,
`endif
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]  fwd_data
);

    wb_state_e          state_q, state_d;
    logic [RADDR_W-1:0] pend_rd_q;
    logic               pend_we_q;
    logic [1:0]         pend_size_q;
    logic               pend_signed_q;
    logic [1:0]         pend_off_q;

    logic               rf_we_q;
    logic [RADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0]  rf_wdata_q;

    logic               accept;
    logic               done;
    logic               latch;
    logic               wr_en;
    logic [RADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  src_data;
    logic [DATA_W-1:0]  ld_data;
    logic               zero_hit;

    logic [1:0]         al_size;
    logic               al_signed;
    logic [1:0]         al_off;

    // While waiting, the aligner must use the load attributes captured at accept.
    assign al_size   = (state_q == WAIT_MEM) ? pend_size_q   : ld_size;
    assign al_signed = (state_q == WAIT_MEM) ? pend_signed_q : ld_signed;
    assign al_off    = (state_q == WAIT_MEM) ? pend_off_q    : ld_offset;

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .mem_rdata_i (mem_rdata),
        .ld_size_i   (al_size),
        .ld_signed_i (al_signed),
        .ld_offset_i (al_off),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        case (wb_sel)
            WB_ALU:  src_data = alu_result;
            WB_MEM:  src_data = ld_data;
            WB_PC:   src_data = pc_link;
            default: src_data = imm;
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        latch   = 1'b0;
        wr_en   = reg_write;
        wr_rd   = rd;
        wr_data = src_data;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wb_sel != WB_MEM || mem_rvalid) begin
                        done = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_d = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                wr_en   = pend_we_q;
                wr_rd   = pend_rd_q;
                wr_data = ld_data;
                if (mem_rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign zero_hit = (ZERO_REG_EN != 0) && (wr_rd == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pend_rd_q     <= '0;
            pend_we_q     <= 1'b0;
            pend_size_q   <= '0;
            pend_signed_q <= 1'b0;
            pend_off_q    <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                pend_rd_q     <= rd;
                pend_we_q     <= reg_write;
                pend_size_q   <= ld_size;
                pend_signed_q <= ld_signed;
                pend_off_q    <= ld_offset;
            end
            rf_we_q <= done && wr_en && !zero_hit;
            // Address and data still update on suppressed writes; they hold otherwise.
            if (done) begin
                rf_waddr_q <= wr_rd;
                rf_wdata_q <= wr_data;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (done) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`endif

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign fwd_valid = rf_we_q;
    assign fwd_rd    = rf_waddr_q;
    assign fwd_data  = rf_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_p.sv
// ============================================================================
// Module      : tb_wb_stage_p
// Description : Directed scoreboard bench for wb_stage_p.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_sel;
    logic        reg_write;
    logic [5:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_link;
    logic [31:0] imm;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  ld_offset;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [5:0]  fwd_rd;
    logic [31:0] fwd_data;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    wb_stage_p #(
        .DATA_W      (32),
        .RADDR_W     (6),
        .ZERO_REG_EN (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wb_sel     (wb_sel),
        .reg_write  (reg_write),
        .rd         (rd),
        .alu_result (alu_result),
        .pc_link    (pc_link),
        .imm        (imm),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .ld_offset  (ld_offset),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt (retire_cnt),
`endif
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
    );

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [5:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] exp_retire = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [5:0] addr, input logic [31:0] data);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] sel, input logic rw, input logic [5:0] r,
                         input logic [31:0] val);
        in_valid   = 1'b1;
        wb_sel     = sel;
        reg_write  = rw;
        rd         = r;
        alu_result = (sel == 2'd0) ? val : 32'h5A5A_0000;
        pc_link    = (sel == 2'd2) ? val : 32'h6B6B_0000;
        imm        = (sel == 2'd3) ? val : 32'h7C7C_0000;
    endtask

    task automatic drive_load(input logic rw, input logic [5:0] r, input logic [1:0] sz,
                              input logic sgn, input logic [1:0] off, input logic rv,
                              input logic [31:0] data);
        drive(2'd1, rw, r, 32'h0);
        ld_size    = sz;
        ld_signed  = sgn;
        ld_offset  = off;
        mem_rvalid = rv;
        mem_rdata  = data;
    endtask

    task automatic quiet();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic expect_write(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_we"},    {31'd0, rf_we},     {31'd0, e.we});
            chk({tag, "_fwdv"},  {31'd0, fwd_valid}, {31'd0, e.we});
            chk({tag, "_waddr"}, {26'd0, rf_waddr},  {26'd0, e.addr});
            chk({tag, "_fwdrd"}, {26'd0, fwd_rd},    {26'd0, e.addr});
            chk({tag, "_wdata"}, rf_wdata,           e.data);
            chk({tag, "_fwdd"},  fwd_data,           e.data);
            last_addr = e.addr;
            last_data = e.data;
            exp_retire = exp_retire + 32'd1;
`ifdef WB_RETIRE_CNT_EN
            chk({tag, "_retire"}, retire_cnt, exp_retire);
`endif
        end
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_we0"},   {31'd0, rf_we},     32'd0);
        chk({tag, "_fwdv0"}, {31'd0, fwd_valid}, 32'd0);
        chk({tag, "_hold_a"}, {26'd0, rf_waddr}, {26'd0, last_addr});
        chk({tag, "_hold_d"}, rf_wdata,          last_data);
`ifdef WB_RETIRE_CNT_EN
        chk({tag, "_retire"}, retire_cnt, exp_retire);
`endif
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; wb_sel = 2'd0; reg_write = 1'b0; rd = '0;
        alu_result = '0; pc_link = '0; imm = '0;
        ld_size = 2'd0; ld_signed = 1'b0; ld_offset = 2'd0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        expect_idle("rst");
        chk("rst_fwd_rd", {26'd0, fwd_rd}, 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        rst = 1'b0;
        tick();

        // ALU path
        drive(2'd0, 1'b1, 6'd5, 32'h0000_1234);
        push(1'b1, 6'd5, 32'h0000_1234);
        tick();
        quiet();
        expect_write("alu");
        chk("alu_ready", {31'd0, in_ready}, 32'd1);
        tick();
        expect_idle("alu_after");

        // Byte loads, lane 2 of 0x1180_2233
        drive_load(1'b1, 6'd7, 2'd0, 1'b1, 2'd2, 1'b1, 32'h1180_2233);
        push(1'b1, 6'd7, 32'hFFFF_FF80);
        tick();
        drive_load(1'b1, 6'd8, 2'd0, 1'b0, 2'd2, 1'b1, 32'h1180_2233);
        push(1'b1, 6'd8, 32'h0000_0080);
        expect_write("lb_s");
        tick();
        quiet();
        expect_write("lb_u");

        // Late memory: live load attributes change while waiting
        drive_load(1'b1, 6'd9, 2'd2, 1'b0, 2'd0, 1'b0, 32'hDEAD_0000);
        push(1'b1, 6'd9, 32'hCAFE_BABE);
        tick();
        quiet();
        rd = 6'd3; ld_size = 2'd0; ld_signed = 1'b1; ld_offset = 2'd3;
        for (int i = 0; i < 3; i++) begin
            chk("late_ready0", {31'd0, in_ready}, 32'd0);
            expect_idle("late_wait");
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_BABE;
        chk("late_ready_resp", {31'd0, in_ready}, 32'd0);
        tick();
        expect_write("late");
        chk("late_ready1", {31'd0, in_ready}, 32'd1);
        // mem_rvalid still high with nothing pending must not write
        tick();
        expect_idle("stray_rvalid");
        quiet();

        // Zero register suppression: data still updates
        drive(2'd0, 1'b1, 6'd0, 32'hFFFF_FFFF);
        push(1'b0, 6'd0, 32'hFFFF_FFFF);
        tick();
        quiet();
        expect_write("zero");
        tick();
        expect_idle("zero_after");

        // Reset during WAIT_MEM with a concurrent response
        drive_load(1'b1, 6'd10, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
        tick();
        quiet();
        chk("rw_wait_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b0;
        last_addr = '0; last_data = '0; exp_retire = '0;
        chk("rw_ready", {31'd0, in_ready}, 32'd1);
        expect_idle("rw_rst");
        tick();
        expect_idle("rw_after");

        // Back-to-back ALU / PC / IMM / ALU
        for (int i = 1; i <= 4; i++) begin
            logic [1:0]  sel;
            logic [31:0] v;
            sel = (i == 2) ? 2'd2 : (i == 3) ? 2'd3 : 2'd0;
            v   = 32'h1000_0000 + 32'(i * 17);
            drive(sel, 1'b1, 6'(i), v);
            push(1'b1, 6'(i), v);
            if (i > 1) expect_write("b2b");
            chk("b2b_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        quiet();
        expect_write("b2b_last");
        tick();
        expect_idle("b2b_after");

        // Halfword loads; odd offset aligns down
        drive_load(1'b1, 6'd11, 2'd1, 1'b0, 2'd2, 1'b1, 32'hABCD_0001);
        push(1'b1, 6'd11, 32'h0000_ABCD);
        tick();
        drive_load(1'b1, 6'd12, 2'd1, 1'b1, 2'd3, 1'b1, 32'h8001_0000);
        push(1'b1, 6'd12, 32'hFFFF_8001);
        expect_write("lhu");
        tick();
        drive_load(1'b0, 6'd13, 2'd3, 1'b1, 2'd1, 1'b1, 32'h8765_4321);
        push(1'b0, 6'd13, 32'h8765_4321);
        expect_write("lh_s_odd");
        tick();
        quiet();
        expect_write("lw_nowrite");
        tick();
        expect_idle("final");

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
